// File: rtl/sar_value_finder_if.sv
// Handshake/data bundle between the SAR controller and its environment:
// start request, comparator {G,E,L} result, and the search outputs.
interface sar_value_finder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [2:0]       r_in;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, r_in,
    input  guess, busy, done, result, err
  );

  modport slave (
    input  start, r_in,
    output guess, busy, done, result, err
  );
endinterface

// File: rtl/sar_value_finder.sv
// Successive-approximation controller recovering a WIDTH-bit operand B via an
// external comparator. Optional macro SAR_EARLY_EXIT_EN: finish on first E hit.
module sar_value_finder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  sar_value_finder_if.slave  bus
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] guess;
  logic             one_hot;
  logic             keep_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  // A malformed comparator sample is handled like G: the trial bit is dropped.
  always_comb begin
    trial_bit = WIDTH'(1) << idx_q;
    guess     = (state_q == TRIAL) ? (acc_q | trial_bit) : '0;
    one_hot   = (bus.r_in == 3'b100) || (bus.r_in == 3'b010) || (bus.r_in == 3'b001);
    keep_bit  = one_hot && !bus.r_in[2];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = TRIAL;
          acc_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          err_d   = 1'b0;
        end
      end
      TRIAL: begin
        if (!one_hot) err_d = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
        if (bus.r_in == 3'b010) begin
          result_d = guess;
          state_d  = DONE;
        end else begin
          acc_d = keep_bit ? (acc_q | trial_bit) : (acc_q & ~trial_bit);
          if (idx_q == '0) begin
            result_d = acc_d;
            state_d  = DONE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
`else
        acc_d = keep_bit ? (acc_q | trial_bit) : (acc_q & ~trial_bit);
        if (idx_q == '0) begin
          result_d = acc_d;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.guess  = guess;
  assign bus.busy   = (state_q == TRIAL);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule
